// File: rtl/comparator_request_sequencer.sv
// Initiator-side controller for the power-gated multi-bit comparator.
// Takes one operand pair at a time, drives it onto the comparator, pulses
// the comparator clear, waits for a settled result, checks that the result
// flags are one-hot and returns the verdict with timeout/error reporting.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. A producer holding valid may not change its payload
// until the transfer. Ready may depend on state only, never on valid.
module comparator_request_sequencer #(
    parameter int N       = 3,
    parameter int TAG_W   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N:0]       req_a,
    input  logic [N:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [N:0]       cmp_a,
    output logic [N:0]       cmp_b,
    output logic             cmp_clear,
    input  logic             cmp_less,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_solved,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_less,
    output logic             rsp_equal,
    output logic             rsp_greater,
    output logic             rsp_timeout,
    output logic             rsp_error,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      stat_done,
    output logic [7:0]       stat_fault,
    output logic [1:0]       dbg_state
);

    // Wide enough to hold TIMEOUT itself, so the increment on the exit
    // cycle never truncates.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SETTLE_C       = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q,       state_d;
    logic [N:0]       cmp_a_q,       cmp_a_d;
    logic [N:0]       cmp_b_q,       cmp_b_d;
    logic             cmp_clear_q,   cmp_clear_d;
    logic [CNT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic             rsp_valid_q,   rsp_valid_d;
    logic             rsp_less_q,    rsp_less_d;
    logic             rsp_equal_q,   rsp_equal_d;
    logic             rsp_greater_q, rsp_greater_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             rsp_error_q,   rsp_error_d;
    logic [TAG_W-1:0] tag_q,         tag_d;
    logic [15:0]      stat_done_q,   stat_done_d;
    logic [7:0]       stat_fault_q,  stat_fault_d;

    logic [2:0] flags;
    logic       flags_onehot;
    logic       solve_ok;

    assign flags        = {cmp_less, cmp_equal, cmp_greater};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    // Comparator outputs are only trusted once the settle window has passed.
    assign solve_ok     = (wait_cnt_q >= SETTLE_C) && cmp_solved;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cmp_a_d       = cmp_a_q;
        cmp_b_d       = cmp_b_q;
        cmp_clear_d   = 1'b0;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_less_d    = rsp_less_q;
        rsp_equal_d   = rsp_equal_q;
        rsp_greater_d = rsp_greater_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_error_d   = rsp_error_q;
        tag_d         = tag_q;
        stat_done_d   = stat_done_q;
        stat_fault_d  = stat_fault_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cmp_a_d     = req_a;
                    cmp_b_d     = req_b;
                    tag_d       = req_tag;
                    cmp_clear_d = 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                // A solve on the last allowed cycle takes priority over timeout.
                if (solve_ok) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_error_d   = !flags_onehot;
                    rsp_less_d    = flags_onehot && cmp_less;
                    rsp_equal_d   = flags_onehot && cmp_equal;
                    rsp_greater_d = flags_onehot && cmp_greater;
                    state_d       = S_RESP;
                end else if (wait_cnt_q == TIMEOUT_LAST_C) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_error_d   = 1'b0;
                    rsp_less_d    = 1'b0;
                    rsp_equal_d   = 1'b0;
                    rsp_greater_d = 1'b0;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (stat_done_q != 16'hFFFF) begin
                        stat_done_d = stat_done_q + 16'd1;
                    end
                    if ((rsp_timeout_q || rsp_error_q) && (stat_fault_q != 8'hFF)) begin
                        stat_fault_d = stat_fault_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmp_a_q       <= '0;
            cmp_b_q       <= '0;
            cmp_clear_q   <= 1'b1;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_less_q    <= 1'b0;
            rsp_equal_q   <= 1'b0;
            rsp_greater_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_error_q   <= 1'b0;
            tag_q         <= '0;
            stat_done_q   <= '0;
            stat_fault_q  <= '0;
        end else begin
            state_q       <= state_d;
            cmp_a_q       <= cmp_a_d;
            cmp_b_q       <= cmp_b_d;
            cmp_clear_q   <= cmp_clear_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_less_q    <= rsp_less_d;
            rsp_equal_q   <= rsp_equal_d;
            rsp_greater_q <= rsp_greater_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_error_q   <= rsp_error_d;
            tag_q         <= tag_d;
            stat_done_q   <= stat_done_d;
            stat_fault_q  <= stat_fault_d;
        end
    end

    // req_ready is the only combinational output; forced low during reset.
    assign req_ready   = (state_q == S_IDLE) && !reset;

    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign cmp_clear   = cmp_clear_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_less    = rsp_less_q;
    assign rsp_equal   = rsp_equal_q;
    assign rsp_greater = rsp_greater_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_tag     = tag_q;
    assign stat_done   = stat_done_q;
    assign stat_fault  = stat_fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_comparator_request_sequencer.sv
// Directed bench for comparator_request_sequencer with a small behavioural
// comparator model whose solve timing and flag behaviour are selectable.
module tb_comparator_request_sequencer;

    localparam int N     = 3;
    localparam int TAG_W = 4;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_BAD    = 2;

    // Clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic             req_valid;
    logic             req_ready;
    logic [N:0]       req_a;
    logic [N:0]       req_b;
    logic [TAG_W-1:0] req_tag;
    logic [N:0]       cmp_a;
    logic [N:0]       cmp_b;
    logic             cmp_clear;
    logic             cmp_less;
    logic             cmp_equal;
    logic             cmp_greater;
    logic             cmp_solved;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_less;
    logic             rsp_equal;
    logic             rsp_greater;
    logic             rsp_timeout;
    logic             rsp_error;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      stat_done;
    logic [7:0]       stat_fault;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    int model_mode  = M_NORMAL;
    int solve_dly   = 1;
    int since_clear = 0;

    comparator_request_sequencer #(
        .N(N), .TAG_W(TAG_W), .SETTLE(2), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_clear(cmp_clear),
        .cmp_less(cmp_less), .cmp_equal(cmp_equal),
        .cmp_greater(cmp_greater), .cmp_solved(cmp_solved),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_less(rsp_less), .rsp_equal(rsp_equal), .rsp_greater(rsp_greater),
        .rsp_timeout(rsp_timeout), .rsp_error(rsp_error), .rsp_tag(rsp_tag),
        .stat_done(stat_done), .stat_fault(stat_fault), .dbg_state(dbg_state)
    );

    // Comparator model: counts cycles since clear fell; solves after solve_dly.
    always @(posedge clock) begin
        if (cmp_clear) since_clear <= 0;
        else if (since_clear < 255) since_clear <= since_clear + 1;
    end

    assign cmp_solved  = (model_mode != M_NEVER) && !cmp_clear && (since_clear >= solve_dly);
    assign cmp_less    = (model_mode == M_BAD) ? 1'b1 : (cmp_a < cmp_b);
    assign cmp_equal   = (model_mode == M_BAD) ? 1'b0 : (cmp_a == cmp_b);
    assign cmp_greater = (model_mode == M_BAD) ? 1'b1 : (cmp_a > cmp_b);

    // Driver tasks: all start and end just after a falling edge.
    task automatic wait_idle();
        int k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic send_req(input logic [N:0] a, input logic [N:0] b, input logic [TAG_W-1:0] tag);
        wait_idle();
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles, output int clears);
        cycles = 0;
        clears = 0;
        while (!rsp_valid && cycles < 40) begin
            if (cmp_clear) clears++;
            @(negedge clock);
            cycles++;
        end
        if (!rsp_valid) cycles = -1;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({req_ready, cmp_clear, rsp_valid, dbg_state} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_ctrl: ready/clear/valid/state=%b required 01000",
                     {req_ready, cmp_clear, rsp_valid, dbg_state});
        end
        n_checks++;
        if ({cmp_a, cmp_b, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag, stat_done, stat_fault} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: cmp_a=%0h cmp_b=%0h tag=%0h done=%0h fault=%0h required all 0",
                     cmp_a, cmp_b, rsp_tag, stat_done, stat_fault);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({req_ready, cmp_clear} !== 2'b10) begin
            n_errors++;
            $display("FAIL idle_after_reset: ready/clear=%b required 10", {req_ready, cmp_clear});
        end
    endtask

    task automatic test_greater();
        int cyc, clr;
        model_mode = M_NORMAL;
        solve_dly  = 1;
        send_req(4'b1010, 4'b0110, 4'd3);
        wait_rsp(cyc, clr);
        n_checks++;
        if (cyc !== 4) begin
            n_errors++;
            $display("FAIL greater_latency: got %0d cycles, expected 4", cyc);
        end
        n_checks++;
        if (clr !== 1) begin
            n_errors++;
            $display("FAIL greater_clear_width: got %0d cycles, expected 1", clr);
        end
        n_checks++;
        if ({rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag} !== {5'b00100, 4'd3}) begin
            n_errors++;
            $display("FAIL greater_verdict: l/e/g/to/err/tag=%b required 001000011",
                     {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag});
        end
        take_rsp();
        n_checks++;
        if ({stat_done, stat_fault, req_ready} !== {16'd1, 8'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL greater_stats: done=%0d fault=%0d ready=%0b required 1 0 1",
                     stat_done, stat_fault, req_ready);
        end
    endtask

    task automatic test_equal_backpressure();
        int cyc, clr;
        int bad = 0;
        send_req(4'b0111, 4'b0111, 4'd5);
        wait_rsp(cyc, clr);
        n_checks++;
        if (cyc !== 4) begin
            n_errors++;
            $display("FAIL equal_latency: got %0d cycles, expected 4", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag, req_ready}
                !== {6'b101000, 4'd5, 1'b0}) begin
                n_errors++;
                bad++;
                $display("FAIL equal_hold[%0d]: v/l/e/g/to/err/tag/ready=%b required 101000_0101_0",
                         i, {rsp_valid, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag, req_ready});
            end
            @(negedge clock);
        end
        take_rsp();
        n_checks++;
        if ({req_ready, rsp_valid, stat_done} !== {1'b1, 1'b0, 16'd2}) begin
            n_errors++;
            $display("FAIL equal_release: ready=%0b valid=%0b done=%0d required 1 0 2",
                     req_ready, rsp_valid, stat_done);
        end
    endtask

    task automatic test_timeout();
        int cyc, clr;
        model_mode = M_NEVER;
        send_req(4'b0001, 4'b0000, 4'd7);
        wait_rsp(cyc, clr);
        n_checks++;
        if (cyc !== 17) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d cycles, expected 17", cyc);
        end
        n_checks++;
        if ({rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag} !== {5'b00010, 4'd7}) begin
            n_errors++;
            $display("FAIL timeout_verdict: l/e/g/to/err/tag=%b required 000100111",
                     {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag});
        end
        take_rsp();
        n_checks++;
        if ({stat_done, stat_fault} !== {16'd3, 8'd1}) begin
            n_errors++;
            $display("FAIL timeout_stats: done=%0d fault=%0d required 3 1", stat_done, stat_fault);
        end
    endtask

    task automatic test_error_and_late_solve();
        int cyc, clr;
        model_mode = M_BAD;
        solve_dly  = 1;
        send_req(4'b0100, 4'b0010, 4'd8);
        wait_rsp(cyc, clr);
        n_checks++;
        if ({cyc == 4, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error} !== 6'b100001) begin
            n_errors++;
            $display("FAIL error_verdict: cyc=%0d l/e/g/to/err=%b required 4 00001",
                     cyc, {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error});
        end
        take_rsp();
        n_checks++;
        if ({stat_done, stat_fault} !== {16'd4, 8'd2}) begin
            n_errors++;
            $display("FAIL error_stats: done=%0d fault=%0d required 4 2", stat_done, stat_fault);
        end
        // Solve arrives on the last allowed WAIT cycle: verdict wins.
        model_mode = M_NORMAL;
        solve_dly  = 15;
        send_req(4'b0001, 4'b0010, 4'd10);
        wait_rsp(cyc, clr);
        n_checks++;
        if ({cyc == 17, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag} !== {6'b110000, 4'd10}) begin
            n_errors++;
            $display("FAIL late_solve: cyc=%0d l/e/g/to/err=%b tag=%0d required 17 10000 10",
                     cyc, {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error}, rsp_tag);
        end
        take_rsp();
        // One cycle later is too late: timeout.
        solve_dly = 16;
        send_req(4'b0001, 4'b0010, 4'd11);
        wait_rsp(cyc, clr);
        n_checks++;
        if ({cyc == 17, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error} !== 6'b100010) begin
            n_errors++;
            $display("FAIL too_late_solve: cyc=%0d l/e/g/to/err=%b required 17 00010",
                     cyc, {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error});
        end
        take_rsp();
        n_checks++;
        if ({stat_done, stat_fault} !== {16'd6, 8'd3}) begin
            n_errors++;
            $display("FAIL late_stats: done=%0d fault=%0d required 6 3", stat_done, stat_fault);
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc, clr;
        int seen = 0;
        model_mode = M_NORMAL;
        solve_dly  = 1;
        send_req(4'b1111, 4'b0000, 4'd12);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmp_clear, rsp_valid, req_ready, stat_done, stat_fault} !== {3'b100, 16'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL mid_reset: clear=%0b valid=%0b ready=%0b done=%0d fault=%0d required 1 0 0 0 0",
                     cmp_clear, rsp_valid, req_ready, stat_done, stat_fault);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(negedge clock);
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL mid_reset_no_rsp: rsp_valid high %0d cycles, required 0", seen);
        end
        send_req(4'b0011, 4'b1000, 4'd9);
        wait_rsp(cyc, clr);
        n_checks++;
        if ({cyc == 4, rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error, rsp_tag} !== {6'b110000, 4'd9}) begin
            n_errors++;
            $display("FAIL after_reset_txn: cyc=%0d l/e/g/to/err=%b tag=%0d required 4 10000 9",
                     cyc, {rsp_less, rsp_equal, rsp_greater, rsp_timeout, rsp_error}, rsp_tag);
        end
        take_rsp();
        n_checks++;
        if ({stat_done, stat_fault} !== {16'd1, 8'd0}) begin
            n_errors++;
            $display("FAIL after_reset_stats: done=%0d fault=%0d required 1 0", stat_done, stat_fault);
        end
    endtask

    task automatic test_saturation();
        int cyc, clr;
        model_mode = M_NORMAL;
        solve_dly  = 1;
        // Held across one rising edge so the register itself loads the value.
        force dut.stat_done_q = 16'hFFFE;
        @(negedge clock);
        release dut.stat_done_q;
        n_checks++;
        if (stat_done !== 16'hFFFE) begin
            n_errors++;
            $display("FAIL sat_preload: done=%0h required fffe", stat_done);
        end
        for (int i = 0; i < 3; i++) begin
            send_req(4'(i), 4'd2, 4'(i));
            wait_rsp(cyc, clr);
            take_rsp();
            n_checks++;
            if (stat_done !== 16'hFFFF) begin
                n_errors++;
                $display("FAIL sat_done[%0d]: done=%0h required ffff", i, stat_done);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_greater();
        test_equal_backpressure();
        test_timeout();
        test_error_and_late_solve();
        test_reset_mid_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
